// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared definitions for the CPU/DMA bus arbiter.
//   arb_state_t : arbiter state encoding (S_CPU, S_DMA, S_HOLD)
//   ARB_CW      : width of the burst and hold counters
//   AW, DW      : bus address / data widths, shared with the CPU top
package bus_arb_pkg;

  typedef enum logic [1:0] {
    S_CPU  = 2'd0,
    S_DMA  = 2'd1,
    S_HOLD = 2'd2
  } arb_state_t;

  localparam int ARB_CW = 8;
  localparam int AW     = 16;
  localparam int DW     = 8;

endpackage

// File: rtl/bus_arb_cnt.sv
// arb_cnt: loadable up/down counter with enable and compare flags.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (count -> 0)
//   load      : load load_val (has priority over en)
//   load_val  : value loaded on load
//   en        : count one step in the direction given by up
//   up        : 1 = count up, 0 = count down
//   cmp_val   : compare value for is_cmp
//   cnt       : current count
//   is_zero   : cnt == 0
//   is_cmp    : cnt == cmp_val
// The count never wraps: it holds at all-ones going up and at 0 going down.
module arb_cnt
  import bus_arb_pkg::*;
#(
  parameter int CW = ARB_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  input  logic          up,
  input  logic [CW-1:0] cmp_val,
  output logic [CW-1:0] cnt,
  output logic          is_zero,
  output logic          is_cmp
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      if (up && (cnt_q != '1)) begin
        cnt_d = cnt_q + CW'(1);
      end else if (!up && (cnt_q != '0)) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign is_zero = (cnt_q == '0);
  assign is_cmp  = (cnt_q == cmp_val);

endmodule

// File: rtl/bus_arb.sv
// bus_arb: shares the 65C02 memory bus between the CPU and one DMA requester.
// The CPU is paused through RDY while DMA owns the bus. DMA bursts are capped
// at MAX_BURST transfers, after which the CPU gets at least CPU_MIN completed
// cycles before DMA can be granted again.
// Ports:
//   clk, RST                  : clock, asynchronous active-high reset
//   cpu_ad/cpu_do/cpu_we      : CPU bus request
//   cpu_sync                  : CPU opcode-fetch marker (only with BUS_ARB_SYNC_EN)
//   cpu_rdy                   : CPU RDY, 0 pauses the core
//   ext_rdy                   : memory ready, 0 inserts a wait state
//   dma_req                   : DMA bus request (level)
//   dma_ad/dma_do/dma_we      : DMA bus request
//   dma_gnt                   : DMA owns the bus this cycle
//   dma_ack                   : a DMA transfer completes this cycle
//   mem_ad/mem_do/mem_we      : shared memory bus
// Build option: BUS_ARB_SYNC_EN -- grant DMA only on CPU opcode-fetch cycles.
module bus_arb
  import bus_arb_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int CPU_MIN   = 4
) (
  input  logic          clk,
  input  logic          RST,
  input  logic [AW-1:0] cpu_ad,
  input  logic [DW-1:0] cpu_do,
  input  logic          cpu_we,
  input  logic          cpu_sync,
  output logic          cpu_rdy,
  input  logic          ext_rdy,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_ad,
  input  logic [DW-1:0] dma_do,
  input  logic          dma_we,
  output logic          dma_gnt,
  output logic          dma_ack,
  output logic [AW-1:0] mem_ad,
  output logic [DW-1:0] mem_do,
  output logic          mem_we
);

  arb_state_t state_q, state_d;

  logic grant_ok;
  logic burst_load, burst_en, burst_last, burst_zero;
  logic hold_load, hold_en, hold_zero, hold_cmp;
  logic [ARB_CW-1:0] burst_cnt, hold_cnt;
  logic unused_flags;

`ifdef BUS_ARB_SYNC_EN
  // Only hand the bus over at an instruction boundary.
  assign grant_ok = dma_req & cpu_sync;
`else
  logic unused_sync;
  assign grant_ok    = dma_req;
  assign unused_sync = cpu_sync;
`endif

  always_comb begin
    state_d    = state_q;
    burst_load = 1'b0;
    hold_load  = 1'b0;
    case (state_q)
      S_CPU: begin
        if (grant_ok) begin
          state_d    = S_DMA;
          burst_load = 1'b1;
        end
      end
      S_DMA: begin
        // A dropped request releases even during a wait state.
        if (!dma_req || (ext_rdy && burst_last)) begin
          state_d   = S_HOLD;
          hold_load = 1'b1;
        end
      end
      S_HOLD: begin
        if (hold_zero && ext_rdy) begin
          state_d = S_CPU;
        end
      end
      default: state_d = S_CPU;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= S_CPU;
    end else begin
      state_q <= state_d;
    end
  end

  // The final transfer of a full burst is not counted, so the burst count
  // tops out at MAX_BURST-1.
  assign burst_en = (state_q == S_DMA) && ext_rdy && !burst_last;
  assign hold_en  = (state_q == S_HOLD) && ext_rdy;

  arb_cnt #(.CW(ARB_CW)) u_burst_cnt (
    .clk      (clk),
    .rst      (RST),
    .load     (burst_load),
    .load_val ('0),
    .en       (burst_en),
    .up       (1'b1),
    .cmp_val  (ARB_CW'(MAX_BURST - 1)),
    .cnt      (burst_cnt),
    .is_zero  (burst_zero),
    .is_cmp   (burst_last)
  );

  arb_cnt #(.CW(ARB_CW)) u_hold_cnt (
    .clk      (clk),
    .rst      (RST),
    .load     (hold_load),
    .load_val (ARB_CW'(CPU_MIN - 1)),
    .en       (hold_en),
    .up       (1'b0),
    .cmp_val  ('0),
    .cnt      (hold_cnt),
    .is_zero  (hold_zero),
    .is_cmp   (hold_cmp)
  );

  assign unused_flags = burst_zero ^ hold_cmp ^ (^burst_cnt) ^ (^hold_cnt);

  // Outputs depend on the registered state only, never on dma_req.
  always_comb begin
    mem_ad  = cpu_ad;
    mem_do  = cpu_do;
    mem_we  = cpu_we & ext_rdy;
    cpu_rdy = ext_rdy;
    dma_gnt = 1'b0;
    dma_ack = 1'b0;
    if (state_q == S_DMA) begin
      mem_ad  = dma_ad;
      mem_do  = dma_do;
      mem_we  = dma_we;
      cpu_rdy = 1'b0;
      dma_gnt = 1'b1;
      dma_ack = ext_rdy;
    end
  end

endmodule
